// File: rtl/fp_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_alu_pkg
//  Purpose  : Shared widths, defaults and issuer state encoding for the FP
//             adder issuer.
//  Revision : 1.0  initial release
// ============================================================================
package fp_alu_pkg;

    localparam int FP_DEF_MANT     = 23;
    localparam int FP_DEF_EXP      = 8;
    localparam int FP_DEF_MIN_WAIT = 2;
    localparam int FP_DEF_TIMEOUT  = 64;

    // Full operand width: sign + exponent + mantissa.
    function automatic int fp_width(input int mant, input int expo);
        return mant + expo + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } issuer_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_adder_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : fp_adder_issuer
//  Purpose  : Issues one operand pair at a time into an FP adder over its
//             load/done interface and returns result + overflow on a
//             valid/ready stream. Define FP_ISSUER_TIMEOUT_EN to build the
//             WAIT-state abort after TIMEOUT cycles.
//  Revision : 1.0  initial release
// ============================================================================
module fp_adder_issuer
    import fp_alu_pkg::*;
#(
    parameter int Mantissa_Size = FP_DEF_MANT,
    parameter int Exponent_Size = FP_DEF_EXP,
    parameter int MIN_WAIT      = FP_DEF_MIN_WAIT,
    parameter int TIMEOUT       = FP_DEF_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [Mantissa_Size+Exponent_Size:0] in_a,
    input  logic [Mantissa_Size+Exponent_Size:0] in_b,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [Mantissa_Size+Exponent_Size:0] out_data,
    output logic                                 out_ovf,
    output logic                                 out_tmo,
    output logic                                 add_enable,
    output logic                                 add_load,
    output logic [Mantissa_Size+Exponent_Size:0] add_a,
    output logic [Mantissa_Size+Exponent_Size:0] add_b,
    input  logic [Mantissa_Size+Exponent_Size:0] add_result,
    input  logic                                 add_done,
    input  logic                                 add_ovf
);

    localparam int W = fp_width(Mantissa_Size, Exponent_Size);

`ifdef FP_ISSUER_TIMEOUT_EN
    localparam int CNT_MAX = (TIMEOUT > MIN_WAIT) ? TIMEOUT : MIN_WAIT;
`else
    // Without the abort path the counter only has to reach MIN_WAIT.
    localparam int CNT_MAX = MIN_WAIT + (TIMEOUT * 0);
`endif
    localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] C_MIN_WAIT = CNT_W'(MIN_WAIT);
`ifdef FP_ISSUER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT);
`endif

    issuer_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     add_a_q, add_a_d;
    logic [W-1:0]     add_b_q, add_b_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_tmo_q, out_tmo_d;
    logic             done_ok;

    // A done seen before MIN_WAIT may still belong to the previous operation.
    assign done_ok = add_done && (cnt_q >= C_MIN_WAIT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        out_tmo_d  = out_tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    add_a_d = in_a;
                    add_b_d = in_b;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != C_CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done_ok) begin
                    out_data_d = add_result;
                    out_ovf_d  = add_ovf;
                    out_tmo_d  = 1'b0;
                    state_d    = ST_RESP;
                end
`ifdef FP_ISSUER_TIMEOUT_EN
                else if (cnt_q >= C_TIMEOUT) begin
                    out_data_d = '0;
                    out_ovf_d  = 1'b0;
                    out_tmo_d  = 1'b1;
                    state_d    = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            out_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
            out_tmo_q  <= out_tmo_d;
        end
    end

    // Handshake and adder strobes decode straight from the state register.
    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign out_valid  = (state_q == ST_RESP);
    assign add_load   = (state_q == ST_LOAD);
    assign add_enable = (state_q == ST_LOAD) || (state_q == ST_WAIT);
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign out_data   = out_data_q;
    assign out_ovf    = out_ovf_q;
    assign out_tmo    = out_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_adder_issuer
//  Purpose  : Directed bench for fp_adder_issuer with a behavioural adder that
//             raises done K cycles after load, optionally holding a stale done.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fp_adder_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_tmo;
    logic        add_enable;
    logic        add_load;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_result;
    logic        add_done;
    logic        add_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int load_pulses = 0;
    int resp_count  = 0;

    fp_adder_issuer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_tmo(out_tmo),
        .add_enable(add_enable), .add_load(add_load), .add_a(add_a), .add_b(add_b),
        .add_result(add_result), .add_done(add_done), .add_ovf(add_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural adder: new done/result K cycles after the load edge; in
    // stale mode the previous done stays high for two more cycles.
    int          m_k = 5;
    bit          m_stale = 1'b0;
    bit          m_never = 1'b0;
    logic [31:0] cfg_res = '0;
    logic        cfg_ovf = 1'b0;
    logic        m_started = 1'b0;
    int          m_since = 0;
    logic        m_prev_done = 1'b0;
    logic [31:0] m_res = '0;
    logic [31:0] m_prev_res = '0;
    logic        m_ovf = 1'b0;
    logic        m_prev_ovf = 1'b0;
    logic        m_new;

    always @(posedge clk) begin
        if (add_load) begin
            m_started   <= 1'b1;
            m_since     <= 0;
            m_prev_done <= add_done;
            m_prev_res  <= add_result;
            m_prev_ovf  <= add_ovf;
            m_res       <= cfg_res;
            m_ovf       <= cfg_ovf;
        end else if (m_started && m_since < 100000) begin
            m_since <= m_since + 1;
        end
    end

    assign m_new      = m_started && !m_never && (m_since >= m_k);
    assign add_done   = m_new || (m_stale && m_prev_done && (m_since < 2));
    assign add_result = m_new ? m_res : m_prev_res;
    assign add_ovf    = m_new ? m_ovf : m_prev_ovf;

    always @(posedge clk) begin
        if (add_load) load_pulses++;
        if (out_valid && out_ready) resp_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a pair and return in the LOAD cycle (one negedge after accept).
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        int seen;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || add_load !== 1'b0 || add_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b add_load=%b add_enable=%b required 0000",
                     in_ready, out_valid, add_load, add_enable);
        end
        n_checks++;
        if (out_data !== 32'h0 || add_a !== 32'h0 || add_b !== 32'h0 || out_ovf !== 1'b0 || out_tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%h add_a=%h add_b=%h ovf=%b tmo=%b required zeros",
                     out_data, add_a, add_b, out_ovf, out_tmo);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
        // Reset in the middle of WAIT must drop the operation silently.
        m_k = 20;
        cfg_res = 32'h1234_5678;
        issue(32'h3F80_0000, 32'h4000_0000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || add_load !== 1'b0 || in_ready !== 1'b1 || add_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop: out_valid=%b add_load=%b in_ready=%b add_enable=%b required 0010",
                     out_valid, add_load, in_ready, add_enable);
        end
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_result: out_valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_basic_add();
        int cyc;
        int lp0;
        lp0 = load_pulses;
        m_k = 5;
        cfg_res = 32'h4000_0000;
        cfg_ovf = 1'b0;
        out_ready = 1'b1;
        issue(32'h3F80_0000, 32'h3F80_0000);
        n_checks++;
        if (add_load !== 1'b1 || add_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_load: add_load=%b add_enable=%b required 11", add_load, add_enable);
        end
        n_checks++;
        if (add_a !== 32'h3F80_0000 || add_b !== 32'h3F80_0000) begin
            n_fail++;
            $display("FAIL basic_operands: add_a=%h add_b=%h required 3f800000 3f800000", add_a, add_b);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: in_ready=%b required 0", in_ready);
        end
        wait_valid(200, cyc);
        n_checks++;
        if (cyc !== 7) begin
            n_fail++;
            $display("FAIL basic_latency: cycles=%0d required 7", cyc);
        end
        n_checks++;
        if (out_data !== 32'h4000_0000 || out_ovf !== 1'b0 || out_tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: data=%h ovf=%b tmo=%b required 40000000 0 0", out_data, out_ovf, out_tmo);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_return: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        n_checks++;
        if (load_pulses - lp0 !== 1) begin
            n_fail++;
            $display("FAIL basic_load_count: pulses=%0d required 1", load_pulses - lp0);
        end
    endtask

    task automatic test_overflow_backpressure();
        int cyc;
        int rc0;
        rc0 = resp_count;
        m_k = 5;
        cfg_res = 32'h7F80_0000;
        cfg_ovf = 1'b1;
        out_ready = 1'b0;
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF);
        wait_valid(200, cyc);
        n_checks++;
        if (out_valid !== 1'b1 || out_ovf !== 1'b1 || out_data !== 32'h7F80_0000) begin
            n_fail++;
            $display("FAIL ovf_result: valid=%b ovf=%b data=%h required 1 1 7f800000", out_valid, out_ovf, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h7F80_0000 || out_ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_hold[%0d]: valid=%b data=%h ovf=%b required 1 7f800000 1", i, out_valid, out_data, out_ovf);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_release: out_valid=%b required 0", out_valid);
        end
        n_checks++;
        if (resp_count - rc0 !== 1) begin
            n_fail++;
            $display("FAIL ovf_resp_count: responses=%0d required 1", resp_count - rc0);
        end
        cfg_ovf = 1'b0;
    endtask

    task automatic test_back_to_back_stale();
        int cyc;
        int rc0;
        int lp0;
        logic [31:0] exp_res;
        rc0 = resp_count;
        lp0 = load_pulses;
        m_stale = 1'b1;
        m_k = 6;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_res = 32'hA5A5_0000 | i;
            cfg_res = exp_res;
            issue(32'h3F80_0000 + i, 32'h4040_0000 + i);
            wait_valid(200, cyc);
            n_checks++;
            if (cyc !== 8) begin
                n_fail++;
                $display("FAIL stale_latency[%0d]: cycles=%0d required 8", i, cyc);
            end
            n_checks++;
            if (out_data !== exp_res) begin
                n_fail++;
                $display("FAIL stale_data[%0d]: data=%h required %h", i, out_data, exp_res);
            end
        end
        @(negedge clk);
        n_checks++;
        if (resp_count - rc0 !== 20 || load_pulses - lp0 !== 20) begin
            n_fail++;
            $display("FAIL stale_counts: responses=%0d loads=%0d required 20 20",
                     resp_count - rc0, load_pulses - lp0);
        end
        m_stale = 1'b0;
    endtask

`ifdef FP_ISSUER_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        m_never = 1'b1;
        out_ready = 1'b1;
        issue(32'h3F80_0000, 32'h3F80_0000);
        wait_valid(300, cyc);
        n_checks++;
        if (cyc !== 66 || out_tmo !== 1'b1 || out_data !== 32'h0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_abort: cycles=%0d tmo=%b data=%h ovf=%b required 66 1 0 0", cyc, out_tmo, out_data, out_ovf);
        end
        @(negedge clk);
        m_never = 1'b0;
        m_k = 64;
        cfg_res = 32'h4080_0000;
        issue(32'h4000_0000, 32'h4000_0000);
        wait_valid(300, cyc);
        n_checks++;
        if (cyc !== 66 || out_tmo !== 1'b0 || out_data !== 32'h4080_0000) begin
            n_fail++;
            $display("FAIL tmo_done_wins: cycles=%0d tmo=%b data=%h required 66 0 40800000", cyc, out_tmo, out_data);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_timeout();
        n_checks++;
        if (out_tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_tied: out_tmo=%b required 0", out_tmo);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_add();
        test_overflow_backpressure();
        test_back_to_back_stale();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
